// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART transmit arbiter: per-requester request,
// byte and end-of-message flag in, accept strobe and one-hot grant out.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   i_req;
  logic [8*NREQ-1:0] i_data;
  logic [NREQ-1:0]   i_last;
  logic [NREQ-1:0]   o_ack;
  logic [NREQ-1:0]   o_grant;

  modport master (
    output i_req,
    output i_data,
    output i_last,
    input  o_ack,
    input  o_grant
  );

  modport slave (
    input  i_req,
    input  i_data,
    input  i_last,
    output o_ack,
    output o_grant
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte streams.
// A grant is held for a whole message and revoked if the owner stalls too long.
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_IDLE = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_tx_arbiter_if.slave req_bus,
  output logic             o_timeout,
  output logic             o_wr,
  output logic [7:0]       o_data,
  input  logic             i_busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_IDLE + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(MAX_IDLE);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NREQ - 1);

  logic [0:0]       state_r;
  logic [NREQ-1:0]  grant_r;
  logic [PTR_W-1:0] grant_idx_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [CNT_W-1:0] idle_cnt_r;
  logic             timeout_r;

  logic             owned_s;
  logic             req_g_s;
  logic             last_g_s;
  logic             accept_s;
  logic             expire_s;
  logic             release_s;
  logic [PTR_W-1:0] pick_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic [7:0]       data_s;

  // First set request bit at or above ptr, wrapping from NREQ-1 back to 0.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] cand;
    logic             found;
    int unsigned      idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = (int'(ptr) + i) % NREQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      oh[k] = (PTR_W'(k) == idx);
    end
    return oh;
  endfunction

  // Owner handshake decode: accept, end-of-message release and stall expiry.
  always_comb begin
    owned_s    = (state_r == ST_OWNED);
    req_g_s    = owned_s && (|(req_bus.i_req & grant_r));
    last_g_s   = |(req_bus.i_last & grant_r);
    accept_s   = req_g_s && !i_busy;
    expire_s   = owned_s && !req_g_s && (idle_cnt_r == IDLE_LIMIT);
    release_s  = (accept_s && last_g_s) || expire_s;
    next_ptr_s = (grant_idx_r == LAST_IDX) ? {PTR_W{1'b0}} : grant_idx_r + PTR_W'(1);
    pick_s     = rr_pick(req_bus.i_req, rr_ptr_r);
  end

  // Byte mux steered by the registered one-hot grant, so i_data only reaches o_data.
  always_comb begin
    data_s = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      data_s = data_s | (req_bus.i_data[8*k +: 8] & {8{grant_r[k]}});
    end
  end

  assign o_wr            = req_g_s;
  assign o_data          = owned_s ? data_s : 8'h00;
  assign o_timeout       = timeout_r;
  assign req_bus.o_ack   = grant_r & {NREQ{accept_s}};
  assign req_bus.o_grant = grant_r;

  // Ownership FSM with round-robin pointer and owner stall counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= {NREQ{1'b0}};
      grant_idx_r <= {PTR_W{1'b0}};
      rr_ptr_r    <= {PTR_W{1'b0}};
      idle_cnt_r  <= {CNT_W{1'b0}};
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          idle_cnt_r <= {CNT_W{1'b0}};
          if (|req_bus.i_req) begin
            state_r     <= ST_OWNED;
            grant_idx_r <= pick_s;
            grant_r     <= to_onehot(pick_s);
          end else begin
            state_r <= ST_IDLE;
            grant_r <= {NREQ{1'b0}};
          end
        end
        ST_OWNED: begin
          if (release_s) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NREQ{1'b0}};
            rr_ptr_r   <= next_ptr_s;
            idle_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= expire_s;
          end else if (req_g_s) begin
            idle_cnt_r <= {CNT_W{1'b0}};
          end else begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          grant_r    <= {NREQ{1'b0}};
          idle_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester models and a busy-stub UART
// are stepped once per clock from a single initial block.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       wr;
  logic [7:0] wdata;
  logic       timeout;

  uart_tx_arbiter_if #(.NREQ(4)) bus ();

  uart_tx_arbiter #(.NREQ(4), .MAX_IDLE(5)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .req_bus   (bus),
    .o_timeout (timeout),
    .o_wr      (wr),
    .o_data    (wdata),
    .i_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdata [4][16];
  logic       mlast [4][16];
  int         mlen [4];
  int         mpos [4];
  int         ack_cnt [4];
  logic [7:0] uart_log [64];
  int         uart_n;
  int         busy_cnt;
  int         busy_cycles = 10;
  logic       force_busy;
  logic [3:0] grant_log [16];
  int         gn;
  int         gap;
  int         gap_bad;
  logic [3:0] prev_grant;
  int         tout_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 4; k++) begin
      mlen[k]    = 0;
      mpos[k]    = 0;
      ack_cnt[k] = 0;
    end
    uart_n     = 0;
    busy_cnt   = 0;
    force_busy = 1'b0;
    busy       = 1'b0;
    gn         = 0;
    gap        = 0;
    gap_bad    = 0;
    prev_grant = 4'b0000;
    tout_cnt   = 0;
  endtask

  task automatic load_msg(input int k, input logic [7:0] base, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      mdata[k][mlen[k]] = base + 8'(i);
      mlast[k][mlen[k]] = last && (i == n - 1);
      mlen[k]++;
    end
  endtask

  task automatic drive_inputs();
    logic [3:0]  r;
    logic [31:0] d;
    logic [3:0]  l;
    r = 4'b0000;
    d = 32'h0;
    l = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (mpos[k] < mlen[k]) begin
        r[k]         = 1'b1;
        d[8*k +: 8]  = mdata[k][mpos[k]];
        l[k]         = mlast[k][mpos[k]];
      end
    end
    bus.i_req  = r;
    bus.i_data = d;
    bus.i_last = l;
  endtask

  function automatic logic all_done();
    logic done;
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (mpos[k] < mlen[k]) done = 1'b0;
    end
    return done;
  endfunction

  // One clock: sample outputs mid-cycle, then update the UART stub and requesters.
  task automatic step();
    logic [3:0] ack_s;
    logic       wr_s;
    logic [7:0] d_s;
    @(negedge clk);
    ack_s = bus.o_ack;
    wr_s  = wr;
    d_s   = wdata;
    @(posedge clk);
    #1;
    if (wr_s && !busy) begin
      if (uart_n < 64) uart_log[uart_n] = d_s;
      uart_n++;
      busy_cnt = busy_cycles;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    busy = force_busy || (busy_cnt != 0);
    for (int k = 0; k < 4; k++) begin
      if (ack_s[k]) begin
        mpos[k]++;
        ack_cnt[k]++;
      end
    end
    drive_inputs();
    if (timeout) tout_cnt++;
    if (bus.o_grant != 4'b0000 && prev_grant == 4'b0000) begin
      if (gn > 0 && gap != 1) gap_bad++;
      if (gn < 16) grant_log[gn] = bus.o_grant;
      gn++;
    end
    if (bus.o_grant == 4'b0000) gap++;
    else gap = 0;
    prev_grant = bus.o_grant;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (all_done() && bus.o_grant == 4'b0000) break;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int bp_wr_bad, bp_ack_bad, bp_cnt_bad, bp_to_bad;

  initial begin
    rst_n = 1'b0;
    reset_model();
    drive_inputs();

    // Reset values and a single 3-byte message from requester 1
    do_reset();
    check_val("rst_grant", bus.o_grant, 4'b0000);
    check_val("rst_wr", wr, 1'b0);
    check_val("rst_ack", bus.o_ack, 4'b0000);
    check_val("rst_data", wdata, 8'h00);
    check_val("rst_timeout", timeout, 1'b0);
    check_val("rst_rr_ptr", dut.rr_ptr_r, 2'd0);
    busy_cycles = 10;
    mdata[1][0] = 8'h48; mlast[1][0] = 1'b0;
    mdata[1][1] = 8'h69; mlast[1][1] = 1'b0;
    mdata[1][2] = 8'h0A; mlast[1][2] = 1'b1;
    mlen[1] = 3;
    drive_inputs();
    step();
    check_val("t1_grant_latency", bus.o_grant, 4'b0010);
    check_val("t1_wr", wr, 1'b1);
    check_val("t1_data", wdata, 8'h48);
    wait_idle(200);
    check_val("t1_ack_count", ack_cnt[1], 3);
    check_val("t1_uart_count", uart_n, 3);
    check_val("t1_byte0", uart_log[0], 8'h48);
    check_val("t1_byte1", uart_log[1], 8'h69);
    check_val("t1_byte2", uart_log[2], 8'h0A);
    check_val("t1_grant_released", bus.o_grant, 4'b0000);
    check_val("t1_rr_ptr", dut.rr_ptr_r, 2'd2);

    // Round robin: four requesters, two 2-byte messages each
    do_reset();
    busy_cycles = 2;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        load_msg(k, 8'((k + 1) * 16 + m * 2), 2, 1'b1);
      end
    end
    drive_inputs();
    wait_idle(400);
    check_val("t2_grant_count", gn, 8);
    check_val("t2_order0", grant_log[0], 4'b0001);
    check_val("t2_order1", grant_log[1], 4'b0010);
    check_val("t2_order2", grant_log[2], 4'b0100);
    check_val("t2_order3", grant_log[3], 4'b1000);
    check_val("t2_order4", grant_log[4], 4'b0001);
    check_val("t2_gap", gap_bad, 0);
    check_val("t2_uart_count", uart_n, 16);
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 2; b++) begin
          check_val($sformatf("t2_byte_m%0d_r%0d_b%0d", m, k, b),
                    uart_log[m * 8 + k * 2 + b], 8'((k + 1) * 16 + m * 2 + b));
        end
      end
    end

    // Priority wrap: rr_ptr=3 with requests from 0 and 2
    do_reset();
    load_msg(2, 8'hC0, 1, 1'b1);
    drive_inputs();
    wait_idle(50);
    check_val("t3_rr_ptr", dut.rr_ptr_r, 2'd3);
    load_msg(0, 8'hD0, 1, 1'b1);
    load_msg(2, 8'hC1, 1, 1'b1);
    drive_inputs();
    wait_idle(100);
    check_val("t3_grant_count", gn, 3);
    check_val("t3_first", grant_log[1], 4'b0001);
    check_val("t3_second", grant_log[2], 4'b0100);

    // Timeout: requester 2 sends one non-last byte then drops its request
    do_reset();
    load_msg(2, 8'hA0, 1, 1'b0);
    load_msg(3, 8'hB0, 1, 1'b1);
    drive_inputs();
    for (int i = 0; i < 20 && ack_cnt[2] == 0; i++) step();
    check_val("t4_byte_accepted", ack_cnt[2], 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i < 6) begin
        check_val($sformatf("t4_no_early_timeout_%0d", i), timeout, 1'b0);
        check_val($sformatf("t4_grant_held_%0d", i), bus.o_grant, 4'b0100);
      end else begin
        check_val("t4_timeout_pulse", timeout, 1'b1);
        check_val("t4_grant_dropped", bus.o_grant, 4'b0000);
      end
    end
    step();
    check_val("t4_next_grant", bus.o_grant, 4'b1000);
    check_val("t4_timeout_low", timeout, 1'b0);
    check_val("t4_timeout_count", tout_cnt, 1);

    // Backpressure: UART busy for 50 cycles while the owner requests
    do_reset();
    force_busy = 1'b1;
    busy = 1'b1;
    load_msg(0, 8'hE0, 1, 1'b1);
    drive_inputs();
    step();
    check_val("t5_grant", bus.o_grant, 4'b0001);
    bp_wr_bad = 0; bp_ack_bad = 0; bp_cnt_bad = 0; bp_to_bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (wr !== 1'b1) bp_wr_bad++;
      if (bus.o_ack !== 4'b0000) bp_ack_bad++;
      if (dut.idle_cnt_r !== 3'd0) bp_cnt_bad++;
      if (timeout !== 1'b0) bp_to_bad++;
    end
    check_val("t5_wr_held", bp_wr_bad, 0);
    check_val("t5_no_ack", bp_ack_bad, 0);
    check_val("t5_idle_cnt_zero", bp_cnt_bad, 0);
    check_val("t5_no_timeout", bp_to_bad, 0);
    force_busy = 1'b0;
    busy = 1'b0;
    wait_idle(30);
    check_val("t5_ack_count", ack_cnt[0], 1);
    check_val("t5_uart_byte", uart_log[0], 8'hE0);

    // Async reset during byte 2 of a message
    do_reset();
    busy_cycles = 10;
    load_msg(1, 8'h50, 3, 1'b1);
    drive_inputs();
    for (int i = 0; i < 30 && ack_cnt[1] == 0; i++) step();
    repeat (3) step();
    check_val("t6_wr_before", wr, 1'b1);
    check_val("t6_grant_before", bus.o_grant, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t6_wr_async", wr, 1'b0);
    check_val("t6_grant_async", bus.o_grant, 4'b0000);
    check_val("t6_ack_async", bus.o_ack, 4'b0000);
    reset_model();
    load_msg(3, 8'h70, 1, 1'b1);
    load_msg(1, 8'h60, 1, 1'b1);
    drive_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_val("t6_first_grant", bus.o_grant, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `wb_uart_tx` transmitter between `NREQ` byte-stream requesters (e.g. several message ROM sequencers). The grant is held for a whole message, from first byte through the byte flagged `i_last`, so messages never interleave on the serial line. A grant is revoked if the owning requester stalls too long. The block sits between the requesters and the transmitter's `i_wr`/`i_data`/`o_busy` handshake.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_IDLE`, 1000: consecutive cycles the owner may hold `i_req` low while granted before the grant is revoked; ≥1.

Ports:
- `i_clk` input 1: clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_req` input NREQ: per-requester write request. Bit k has byte `i_data[8k+7:8k]` valid.
- `i_data` input 8*NREQ: packed request bytes.
- `i_last` input NREQ: bit k marks the current byte of requester k as the final byte of its message.
- `o_ack` output NREQ: bit k is high for one cycle when requester k's byte is accepted by the UART.
- `o_grant` output NREQ: one-hot registered grant; all-zero when idle.
- `o_timeout` output 1: one-cycle pulse when a grant is revoked by timeout.
- `o_wr` output 1: to UART `i_wr`.
- `o_data` output 8: to UART `i_data`.
- `i_busy` input 1: from UART `o_busy`.

## Operation

- States are IDLE and OWNED. The state, `o_grant`, the round-robin pointer `rr_ptr` (clog2(NREQ) bits) and the idle counter (clog2(MAX_IDLE+1) bits) are registers.
- Reset (async, `i_rst_n`=0):
  - state=IDLE, `o_grant`=0, `rr_ptr`=0, idle counter=0, `o_timeout`=0.
  - `o_wr`=0, `o_ack`=0, `o_data`=8'h00.
- IDLE:
  - If `i_req`≠0, select the first set bit searching from index `rr_ptr` upward, wrapping NREQ-1→0.
  - Next cycle: `o_grant`=onehot(sel), state=OWNED, idle counter=0.
  - If `i_req`=0, stay in IDLE.
- OWNED with grant index g:
  - `o_wr` = `i_req[g]` (combinational).
  - `o_data` = `i_data[8g+7:8g]` (combinational).
  - Accept condition: `o_wr && !i_busy`. When it holds, `o_ack[g]`=1; all other `o_ack` bits are always 0.
  - Accept with `i_last[g]`=1 → next cycle state=IDLE, `o_grant`=0, `rr_ptr`=(g+1) mod NREQ.
  - `i_req[g]`=0 → idle counter increments.
  - `i_req[g]`=1 → idle counter clears.
  - Idle counter reaching MAX_IDLE → next cycle state=IDLE, `o_grant`=0, `rr_ptr`=(g+1) mod NREQ, `o_timeout`=1 for that one cycle.
- Outside OWNED: `o_wr`=0, `o_data`=8'h00, `o_ack`=0.
- Requester obligations: once `i_req[k]` is raised while granted, hold it and keep its data stable until `o_ack[k]`. The arbiter does not register or buffer data.
- A requester that is not granted sees `o_ack`=0 and simply waits. Requests are never dropped.
- Boundary cases:
  - Last-byte accept and new requests on the same cycle: release takes priority. Arbitration happens in the following IDLE cycle.
  - Timeout and accept can never coincide, because an accept requires `i_req[g]`=1, which clears the counter.
  - Reset mid-message: the grant is dropped at once and `o_wr` falls asynchronously. The UART may finish the byte already latched. The requester restarts its message.

## Timing

- Grant latency: `i_req` rising at cycle t in IDLE gives `o_grant` valid and `o_wr` high at t+1.
- Byte throughput is limited only by `i_busy`. The arbiter adds no bubbles inside a message.
- Release → next grant: last accept at cycle t → IDLE at t+1 → new grant at t+2. This is a one-cycle arbitration gap.
- Timeout: the grant drops MAX_IDLE+1 cycles after `i_req[g]` falls, if `i_req[g]` stays low throughout.
- `o_ack` is combinational from `i_busy`/`i_req` within the same cycle. There is no combinational path from `i_data` to any control output.

## Test plan

- Reset and single requester: NREQ=4, requester 1 sends 3 bytes 8'h48/8'h69/8'h0A (last on 8'h0A) against a UART stub busy 10 cycles per byte.
  - Required: `o_grant`=4'b0010 one cycle after the request, exactly 3 `o_ack[1]` pulses, UART sees the bytes in order, `o_grant`=0 after the last byte, `rr_ptr`=2.
- Round robin: all four requesters request continuously with 2-byte messages from reset.
  - Required: grant order 0,1,2,3,0.
  - Required: no interleaving of bytes between messages.
  - Required: a one-cycle IDLE gap between grants.
- Priority wrap: `rr_ptr`=3 with requests from 0 and 2 only → grant goes to 0, then 2.
- Timeout: MAX_IDLE=5; requester 2 sends 1 non-last byte, then drops `i_req`.
  - Required: `o_timeout` pulses once, 6 cycles after the drop.
  - Required: `o_grant`=0 and the next waiting requester is granted one cycle later.
- Backpressure: hold `i_busy`=1 for 50 cycles while the owner requests.
  - Required: `o_wr`=1 held throughout, `o_ack`=0 throughout, the idle counter stays 0 and no timeout fires.
- Async reset mid-message: assert `i_rst_n`=0 between clock edges during byte 2.
  - Required: `o_wr`, `o_grant` and `o_ack` go to 0 immediately.
  - Required: after release, the first grant goes to the lowest requesting index.
